// File: rtl/axi_rm_pkg.sv
// rtl/axi_rm_pkg.sv - shared types and AXI encodings for the AXI read master
package axi_rm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DRAIN
    } rm_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rm_beat_t;

endpackage

// File: rtl/axi_read_master_if.sv
// rtl/axi_read_master_if.sv - core request/response port plus AXI AR/R channel bundle
interface axi_read_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_err;

    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        input  req_valid, req_addr, req_len, resp_ready,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
        output req_ready, resp_valid, resp_data, resp_last, resp_err,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY
    );

    modport slave (
        output req_valid, req_addr, req_len, resp_ready,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
        input  req_ready, resp_valid, resp_data, resp_last, resp_err,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY
    );

endinterface

// File: rtl/axi_rm_fifo.sv
// rtl/axi_rm_fifo.sv - synchronous FIFO of returned read beats
module axi_rm_fifo
    import axi_rm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     wr_en,
    input  rm_beat_t wr_data,
    input  logic     rd_en,
    output rm_beat_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    rm_beat_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_wr;
    logic           do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];
    assign do_rd   = rd_en && !empty;
    // A pop frees the head slot this same cycle, so a write into a full FIFO still lands.
    assign do_wr   = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// rtl/axi_read_master.sv - single-outstanding AXI4 INCR read master; AXI_RM_TIMEOUT_EN adds R timeout/DRAIN
module axi_read_master
    import axi_rm_pkg::*;
#(
    parameter logic [3:0] MST_ID         = 4'd0,
    parameter int         FIFO_DEPTH     = 2,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_read_master_if.master  bus
);

    if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi_read_master: FIFO_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    rm_state_t   state;
    logic [31:0] ar_addr;
    logic [3:0]  ar_len;
    logic        ar_valid;
    logic        req_rdy;
    logic [3:0]  beat_cnt;
    logic        overrun;
    logic [31:0] data_hold;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_wr;
    logic        fifo_rd;
    rm_beat_t    fifo_in;
    rm_beat_t    fifo_head;

    logic        r_ready;
    logic        r_hs;
    logic        beat_err;
    logic        tmo_fire;

    assign r_ready = (state == ST_R && !fifo_full) || (state == ST_DRAIN);
    assign r_hs    = bus.RVALID && r_ready;

    // overrun stays set once a non-last beat arrived at the final index, so every later beat is flagged.
    assign beat_err = (bus.RRESP != RESP_OKAY) || (bus.RID != MST_ID) || overrun ||
                      (bus.RLAST ? (beat_cnt != ar_len) : (beat_cnt == ar_len));

`ifdef AXI_RM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 9;
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_fire = (state == ST_R) && r_ready && !r_hs &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    assign fifo_wr = ((state == ST_R) && r_hs) || tmo_fire;
    assign fifo_in = tmo_fire ? {32'h0, 1'b1, 1'b1} : {bus.RDATA, bus.RLAST, beat_err};
    assign fifo_rd = bus.resp_ready;

    axi_rm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (ACLK),
        .resetn  (ARESETn),
        .wr_en   (fifo_wr),
        .wr_data (fifo_in),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.req_ready  = req_rdy;
    assign bus.ARVALID    = ar_valid;
    assign bus.ARADDR     = ar_addr;
    assign bus.ARLEN      = ar_len;
    assign bus.ARID       = MST_ID;
    assign bus.ARSIZE     = SIZE_4B;
    assign bus.ARBURST    = BURST_INCR;
    assign bus.RREADY     = r_ready;
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_data  = fifo_empty ? data_hold : fifo_head.data;
    assign bus.resp_last  = !fifo_empty && fifo_head.last;
    assign bus.resp_err   = !fifo_empty && fifo_head.err;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_valid  <= 1'b0;
            req_rdy   <= 1'b0;
            beat_cnt  <= '0;
            overrun   <= 1'b0;
            data_hold <= '0;
`ifdef AXI_RM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            if (bus.resp_ready && !fifo_empty) begin
                data_hold <= fifo_head.data;
            end
            case (state)
                ST_IDLE: begin
                    if (req_rdy && bus.req_valid) begin
                        ar_addr  <= bus.req_addr & ~32'h3;
                        ar_len   <= bus.req_len;
                        ar_valid <= 1'b1;
                        req_rdy  <= 1'b0;
                        state    <= ST_AR;
                    end else begin
                        req_rdy <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (bus.ARREADY) begin
                        ar_valid <= 1'b0;
                        beat_cnt <= '0;
                        overrun  <= 1'b0;
                        state    <= ST_R;
`ifdef AXI_RM_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        if (beat_cnt != 4'hF) begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                        if (!bus.RLAST && beat_cnt == ar_len) begin
                            overrun <= 1'b1;
                        end
                        if (bus.RLAST) begin
                            state   <= ST_IDLE;
                            req_rdy <= 1'b1;
                        end
                    end
`ifdef AXI_RM_TIMEOUT_EN
                    if (r_hs) begin
                        tmo_cnt <= '0;
                    end else if (tmo_fire) begin
                        tmo_cnt <= '0;
                        state   <= ST_DRAIN;
                    end else if (r_ready) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
`ifdef AXI_RM_TIMEOUT_EN
                ST_DRAIN: begin
                    if (r_hs && bus.RLAST) begin
                        state   <= ST_IDLE;
                        req_rdy <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
